// File: rtl/alu_op_driver.sv
// Initiator-side sequencer for a combinational ALU: one operation in flight,
// registered operands out, settled result returned over a valid/ready stream.
module alu_op_driver #(
    parameter int WIDTH         = 8,
    parameter int MUL_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    input  logic [2:0]           cmd_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_opsel,
    input  logic [MUL_WIDTH-1:0] alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MUL_WIDTH-1:0] rsp_data,
    output logic [2:0]           rsp_op,
    output logic                 rsp_err,
    output logic [CNT_WIDTH-1:0] op_count
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t                 state_q;
    logic [3:0]             settle_q;
    logic [WIDTH-1:0]       alu_a_q;
    logic [WIDTH-1:0]       alu_b_q;
    logic [2:0]             alu_opsel_q;
    logic                   rsp_valid_q;
    logic [MUL_WIDTH-1:0]   rsp_data_q;
    logic [2:0]             rsp_op_q;
    logic                   rsp_err_q;
    logic [CNT_WIDTH-1:0]   op_count_q;
    logic                   cmd_accept_s;

    // In RESP the command port follows the consumer so a new command can ride the response handshake
    always_comb begin
        cmd_ready = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_RESP: cmd_ready = rsp_ready;
            default: cmd_ready = 1'b0;
        endcase
    end

    assign cmd_accept_s = cmd_valid & cmd_ready;

    // Sequencer: operand launch, settle countdown, result capture and completion count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            settle_q    <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_opsel_q <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= 3'd0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            if (cmd_accept_s) begin
                alu_a_q     <= cmd_a;
                alu_b_q     <= cmd_b;
                alu_opsel_q <= cmd_op;
                settle_q    <= SETTLE_INIT;
            end
            case (state_q)
                ST_IDLE: begin
                    state_q <= cmd_accept_s ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (settle_q == 4'd0) begin
                        rsp_data_q  <= alu_result;
                        rsp_op_q    <= alu_opsel_q;
                        rsp_err_q   <= (alu_opsel_q > 3'd5);
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_WIDTH'(1);
                        state_q     <= cmd_accept_s ? ST_WAIT : ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_opsel = alu_opsel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: instance 0 uses SETTLE_CYCLES=1/CNT_WIDTH=8,
// instance 1 uses SETTLE_CYCLES=4/CNT_WIDTH=2; each drives a stub ALU.
module tb_alu_op_driver;
    logic        clk = 1'b0;
    logic        rstn [2];
    logic        cv   [2];
    logic        cr   [2];
    logic [7:0]  ca   [2];
    logic [7:0]  cb   [2];
    logic [2:0]  cop  [2];
    logic [7:0]  aa   [2];
    logic [7:0]  ab   [2];
    logic [2:0]  aop  [2];
    logic [15:0] ar   [2];
    logic        rv   [2];
    logic        rr   [2];
    logic [15:0] rd   [2];
    logic [2:0]  ro   [2];
    logic        re   [2];
    logic [7:0]  oc0;
    logic [1:0]  oc1;

    int n_pass = 0;
    int n_total = 0;
    int hold_bad = 0;
    int exp_cnt [2];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [15:0] d;
        logic        e;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    // Behavioural ALU: add, sub, mul, and, or, xor; codes 6/7 fall back to add
    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
        case (op)
            3'd1:    return 16'(a) - 16'(b);
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return {8'h00, a & b};
            3'd4:    return {8'h00, a | b};
            3'd5:    return {8'h00, a ^ b};
            default: return 16'(a) + 16'(b);
        endcase
    endfunction

    assign ar[0] = alu_model(aa[0], ab[0], aop[0]);
    assign ar[1] = alu_model(aa[1], ab[1], aop[1]);

    alu_op_driver #(.WIDTH(8), .MUL_WIDTH(16), .SETTLE_CYCLES(1), .CNT_WIDTH(8)) u_dut0 (
        .clk(clk), .rst_n(rstn[0]), .cmd_valid(cv[0]), .cmd_ready(cr[0]),
        .cmd_a(ca[0]), .cmd_b(cb[0]), .cmd_op(cop[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_opsel(aop[0]), .alu_result(ar[0]),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_data(rd[0]), .rsp_op(ro[0]),
        .rsp_err(re[0]), .op_count(oc0)
    );

    alu_op_driver #(.WIDTH(8), .MUL_WIDTH(16), .SETTLE_CYCLES(4), .CNT_WIDTH(2)) u_dut1 (
        .clk(clk), .rst_n(rstn[1]), .cmd_valid(cv[1]), .cmd_ready(cr[1]),
        .cmd_a(ca[1]), .cmd_b(cb[1]), .cmd_op(cop[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_opsel(aop[1]), .alu_result(ar[1]),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_data(rd[1]), .rsp_op(ro[1]),
        .rsp_err(re[1]), .op_count(oc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        return (k == 0) ? {24'd0, oc0} : {30'd0, oc1};
    endfunction

    // One command from idle; optional stall of rsp_ready after the response appears
    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input int stall, output logic [15:0] d,
                          output logic [2:0] o, output logic e, output int lat);
        @(negedge clk);
        ca[k] = a; cb[k] = b; cop[k] = op; cv[k] = 1'b1; rr[k] = (stall == 0);
        @(negedge clk);
        cv[k] = 1'b0;
        lat = 0;
        while (!rv[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = rd[k]; o = ro[k]; e = re[k];
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!rv[k] || rd[k] !== d || ro[k] !== o || re[k] !== e) hold_bad++;
        end
        rr[k] = 1'b1;
        @(negedge clk);
        rr[k] = 1'b0;
    endtask

    task automatic do_check(input int k, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op, input int stall,
                            input logic [15:0] exp_d, input logic exp_e);
        logic [15:0] d;
        logic [2:0]  o;
        logic        e;
        int          lat;
        run_op(k, a, b, op, stall, d, o, e, lat);
        chk("latency", lat, (k == 0) ? 1 : 4);
        chk("rsp_data", d, exp_d);
        chk("rsp_op", o, op);
        chk("rsp_err", e, exp_e);
        exp_cnt[k] = (exp_cnt[k] + 1) % ((k == 0) ? 256 : 4);
        chk("op_count", cnt_of(k), exp_cnt[k]);
    endtask

    initial begin
        int w;
        int seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] rop;

        for (int k = 0; k < 2; k++) begin
            rstn[k] = 1'b0; cv[k] = 1'b0; rr[k] = 1'b0;
            ca[k] = 8'd0; cb[k] = 8'd0; cop[k] = 3'd0; exp_cnt[k] = 0;
        end
        tbl[0]  = '{8'd3,   8'd5,   3'd0, 16'h0008, 1'b0};
        tbl[1]  = '{8'd2,   8'd3,   3'd7, 16'h0005, 1'b1};
        tbl[2]  = '{8'hFF,  8'hFF,  3'd2, 16'hFE01, 1'b0};
        tbl[3]  = '{8'd3,   8'd5,   3'd1, 16'hFFFE, 1'b0};
        tbl[4]  = '{8'd0,   8'd0,   3'd0, 16'h0000, 1'b0};
        tbl[5]  = '{8'hFF,  8'd1,   3'd0, 16'h0100, 1'b0};
        tbl[6]  = '{8'd0,   8'd1,   3'd1, 16'hFFFF, 1'b0};
        tbl[7]  = '{8'hF0,  8'h3C,  3'd3, 16'h0030, 1'b0};
        tbl[8]  = '{8'hF0,  8'h0F,  3'd4, 16'h00FF, 1'b0};
        tbl[9]  = '{8'hFF,  8'h0F,  3'd5, 16'h00F0, 1'b0};
        tbl[10] = '{8'd7,   8'd9,   3'd6, 16'h0010, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", rv[0], 1'b0);
        chk("rst_cmd_ready", cr[0], 1'b1);
        chk("rst_op_count", oc0, 8'd0);
        chk("rst_alu_a", aa[0], 8'd0);
        chk("rst_rsp_data", rd[0], 16'd0);
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        for (int i = 0; i < 11; i++)
            do_check(0, tbl[i].a, tbl[i].b, tbl[i].op, 0, tbl[i].d, tbl[i].e);

        // Back-to-back: second command rides the first response handshake
        @(negedge clk);
        ca[0] = 8'd3; cb[0] = 8'd5; cop[0] = 3'd1; cv[0] = 1'b1; rr[0] = 1'b1;
        @(negedge clk);
        ca[0] = 8'hFF; cb[0] = 8'hFF; cop[0] = 3'd2;
        @(negedge clk);
        chk("b2b_rsp1_valid", rv[0], 1'b1);
        chk("b2b_rsp1_data", rd[0], 16'hFFFE);
        chk("b2b_ignored_in_wait", aa[0], 8'd3);
        chk("b2b_cmd_ready", cr[0], 1'b1);
        @(negedge clk);
        cv[0] = 1'b0;
        exp_cnt[0] = (exp_cnt[0] + 1) % 256;
        chk("b2b_count1", oc0, exp_cnt[0]);
        chk("b2b_accept_a", aa[0], 8'hFF);
        chk("b2b_valid_drop", rv[0], 1'b0);
        @(negedge clk);
        chk("b2b_rsp2_valid", rv[0], 1'b1);
        chk("b2b_rsp2_data", rd[0], 16'hFE01);
        chk("b2b_rsp2_op", ro[0], 3'd2);
        @(negedge clk);
        exp_cnt[0] = (exp_cnt[0] + 1) % 256;
        chk("b2b_count2", oc0, exp_cnt[0]);
        rr[0] = 1'b0;

        // Backpressure: response held 10 cycles while a new command waits
        @(negedge clk);
        ca[0] = 8'h0C; cb[0] = 8'h0A; cop[0] = 3'd3; cv[0] = 1'b1;
        @(negedge clk);
        cv[0] = 1'b0;
        w = 0;
        while (!rv[0] && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("stall_rsp_data", rd[0], 16'h0008);
        ca[0] = 8'd1; cb[0] = 8'd2; cop[0] = 3'd0; cv[0] = 1'b1;
        seen = 0;
        repeat (10) begin
            #1;
            if (cr[0] !== 1'b0 || !rv[0] || rd[0] !== 16'h0008 || ro[0] !== 3'd3 ||
                re[0] !== 1'b0 || aa[0] !== 8'h0C || ab[0] !== 8'h0A || aop[0] !== 3'd3)
                seen++;
            @(negedge clk);
        end
        chk("stall_hold", seen, 0);
        rr[0] = 1'b1;
        #1;
        chk("stall_release_ready", cr[0], 1'b1);
        @(negedge clk);
        cv[0] = 1'b0;
        exp_cnt[0] = (exp_cnt[0] + 1) % 256;
        chk("stall_count", oc0, exp_cnt[0]);
        chk("stall_accept_a", aa[0], 8'd1);
        chk("stall_accept_b", ab[0], 8'd2);
        @(negedge clk);
        chk("stall_next_data", rd[0], 16'h0003);
        @(negedge clk);
        exp_cnt[0] = (exp_cnt[0] + 1) % 256;
        chk("stall_next_count", oc0, exp_cnt[0]);
        rr[0] = 1'b0;

        // Randomised traffic against the behavioural ALU model
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom_range(0, 7));
            do_check(0, ra, rb, rop, int'($urandom_range(0, 3)), alu_model(ra, rb, rop), rop > 3'd5);
        end
        chk("rand_hold", hold_bad, 0);

        // Slow instance: counter wraps through 1,2,3,0,1
        for (int i = 0; i < 5; i++)
            do_check(1, 8'(i + 1), 8'd1, 3'd0, 0, 16'(i + 2), 1'b0);

        // Reset mid-settle discards the operation
        @(negedge clk);
        ca[1] = 8'h5A; cb[1] = 8'hA5; cop[1] = 3'd2; cv[1] = 1'b1; rr[1] = 1'b0;
        @(negedge clk);
        cv[1] = 1'b0;
        chk("mid_accept_a", aa[1], 8'h5A);
        @(negedge clk);
        rstn[1] = 1'b0;
        #1;
        chk("async_alu_a", aa[1], 8'd0);
        chk("async_alu_b", ab[1], 8'd0);
        chk("async_alu_op", aop[1], 3'd0);
        chk("async_rsp_valid", rv[1], 1'b0);
        chk("async_rsp_data", rd[1], 16'd0);
        chk("async_rsp_op", ro[1], 3'd0);
        chk("async_rsp_err", re[1], 1'b0);
        chk("async_op_count", oc1, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rstn[1] = 1'b1;
        exp_cnt[1] = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rv[1]) seen = 1;
        end
        chk("no_rsp_after_reset", seen, 0);
        do_check(1, 8'd4, 8'd4, 3'd0, 0, 16'h0008, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
Initiator-side sequencer for the combinational ALU. It accepts operation commands over a valid/ready stream and drives registered operands and opsel onto the ALU input bus. After a fixed settle window it captures the ALU result and returns it over a valid/ready response stream. It sits between a command source (bench or CPU-style controller) and the ALU, and holds one operation in flight at a time.

Parameters:
WIDTH, 8, operand width; must match the ALU's WIDTH.
MUL_WIDTH, 16, result width; must match the ALU's MUL_WIDTH.
SETTLE_CYCLES, 1, cycles between driving the ALU and sampling alu_result; legal range 1..15.
CNT_WIDTH, 8, width of the completed-operation counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid and ready are both high
cmd_a  input  WIDTH  operand a
cmd_b  input  WIDTH  operand b
cmd_op  input  3  ALU opsel
alu_a  output  WIDTH  registered operand a to the ALU
alu_b  output  WIDTH  registered operand b to the ALU
alu_opsel  output  3  registered opsel to the ALU
alu_result  input  MUL_WIDTH  ALU result
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when valid and ready are both high
rsp_data  output  MUL_WIDTH  captured result
rsp_op  output  3  opsel of the operation this response belongs to
rsp_err  output  1  opsel was 6 or 7 (unsupported code; ALU performs add)
op_count  output  CNT_WIDTH  completed responses, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; alu_a, alu_b, alu_opsel, rsp_data, rsp_op, rsp_err, op_count all 0; rsp_valid 0; settle counter 0. Any in-flight operation is discarded and no response is produced for it.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE: cmd_ready=1. On accept at edge T: alu_a/alu_b/alu_opsel load cmd_a/cmd_b/cmd_op; settle counter loads SETTLE_CYCLES-1; next state WAIT.
- WAIT: cmd_ready=0. Settle counter decrements each cycle. At the edge where the counter is 0, and only then:
  - rsp_data is loaded from alu_result;
  - rsp_op is loaded from alu_opsel;
  - rsp_err is set to (alu_opsel > 5);
  - rsp_valid goes to 1 and the state moves to RESP.
- Latency: rsp_valid rises at edge T+SETTLE_CYCLES, counting from the accept edge T.
- RESP: rsp_valid=1. rsp_data, rsp_op and rsp_err are held stable until the response handshake. cmd_ready = rsp_ready (combinational).
  - Response handshake without a new command: rsp_valid goes to 0, op_count increments, next state IDLE.
  - Response handshake and command accept in the same cycle: op_count increments, new operands are loaded, next state WAIT, rsp_valid goes to 0.
  - rsp_ready low: the state holds and cmd_ready=0.
- alu_a, alu_b and alu_opsel change only on a command accept. Between accepts they hold their last values.
- op_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- cmd_* inputs are ignored whenever cmd_ready=0.
- rsp_valid never drops without a handshake, except on reset.
- Maximum throughput is one operation per SETTLE_CYCLES+1 cycles under back-to-back handshakes.
- The driver does not interpret arithmetic. Width effects are the ALU's: results are MUL_WIDTH, subtraction wraps modulo 2^MUL_WIDTH.

Test Plan:
1. SETTLE_CYCLES=1, rsp_ready=1, cmd a=3 b=5 op=0 -> rsp_valid exactly 1 cycle after accept, rsp_data=16'h0008, rsp_op=0, rsp_err=0, op_count=1.
2. a=3 b=5 op=1, then a=8'hFF b=8'hFF op=2, issued back-to-back in RESP with rsp_ready=1 -> responses 16'hFFFE then 16'hFE01; second command accepted the same cycle as the first response; op_count=2.
3. a=2 b=3 op=7 -> rsp_data=16'h0005, rsp_err=1, rsp_op=7.
4. rsp_ready held low 10 cycles after rsp_valid, with cmd_valid high and new operands -> cmd_ready=0 throughout; rsp_data, rsp_op, rsp_err and alu_* stable; after rsp_ready rises, the new command is accepted on the handshake edge.
5. SETTLE_CYCLES=4, rst_n pulsed low 2 cycles after accept (mid-WAIT) -> all outputs 0 immediately (asynchronous); no response emitted; next command completes normally with op_count=1.
6. CNT_WIDTH=2, 5 operations completed -> op_count sequence 1,2,3,0,1.
